// File: rtl/schematic_feeder_if.sv
// schematic_feeder_if
//   Byte-load port and indexed replay stream of the schematic feeder.
//   Load side : in_data/in_valid/in_last from the host, in_ready back.
//   Replay    : counter/value/valid to the scanning engine, ready back.
//   master : the feeder (accepts the load, produces the replay stream).
//   slave  : the environment (host loader plus downstream consumer).
interface schematic_feeder_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] counter;
  logic [7:0]  value;
  logic        valid;
  logic        ready;

  modport master (
    input  in_data, in_valid, in_last, ready,
    output in_ready, counter, value, valid
  );

  modport slave (
    output in_data, in_valid, in_last, ready,
    input  in_ready, counter, value, valid
  );
endinterface

// File: rtl/schematic_feeder.sv
// schematic_feeder
//   Buffers a puzzle byte stream in an internal RAM, measures line width and
//   row count while loading, then replays the buffer as an indexed
//   counter/value/valid stream honouring consumer backpressure.
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   bus        : schematic_feeder_if.master (load port + replay stream)
//   line_width : index of first stored 0x0A plus 1, 0 if none
//   row_count  : rows in the stored input (unterminated last row counted)
//   done       : sticky, playback complete
//   overflow   : sticky, input exceeded the RAM capacity
// Configuration
//   FEEDER_CR_STRIP_EN : when defined, 0x0D bytes are discarded during load.
module schematic_feeder #(
  parameter int ADDR_W = 15
) (
  input  logic               clk,
  input  logic               reset,
  schematic_feeder_if.master bus,
  output logic [15:0]        line_width,
  output logic [15:0]        row_count,
  output logic               done,
  output logic               overflow
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   PTR_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   PTR_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] RD_ZERO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] RD_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_PRIME = 2'd1,
    ST_PLAY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [7:0]        mem_r [DEPTH];
  logic [7:0]        rd_data_r;
  logic [ADDR_W:0]   wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic              last_lf_r;
  logic [15:0]       line_width_r, row_count_r;
  logic              done_r, overflow_r, valid_r;
  logic [7:0]        value_r;
  logic [31:0]       counter_r;

  logic              accept_s, is_lf_s, strip_s, full_s, store_s, drop_s;
  logic              finish_s, last_lf_s, close_row_s, len_zero_s, last_idx_s;
  logic              fill_s, xfer_s, end_s, advance_s, rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;

  assign bus.in_ready = (state_r == ST_LOAD);
  assign bus.counter  = counter_r;
  assign bus.value    = value_r;
  assign bus.valid    = valid_r;
  assign line_width   = line_width_r;
  assign row_count    = row_count_r;
  assign done         = done_r;
  assign overflow     = overflow_r;

  // Load-side qualification and replay-side handshake decode.
  always_comb begin
    accept_s = bus.in_valid & (state_r == ST_LOAD);
    is_lf_s  = (bus.in_data == 8'h0A);
`ifdef FEEDER_CR_STRIP_EN
    strip_s  = (bus.in_data == 8'h0D);
`else
    strip_s  = 1'b0;
`endif
    full_s   = (wr_ptr_r == PTR_FULL);
    store_s  = accept_s & ~strip_s & ~full_s;
    drop_s   = accept_s & ~strip_s & full_s;
    finish_s = accept_s & bus.in_last;
    // The "last stored byte" includes the byte stored on this very edge.
    last_lf_s   = store_s ? is_lf_s : last_lf_r;
    close_row_s = finish_s & (store_s | (wr_ptr_r != PTR_ZERO)) & ~last_lf_s;
    len_zero_s  = (wr_ptr_r == PTR_ZERO);
    last_idx_s  = ((counter_r + 32'd1) == 32'(wr_ptr_r));
    // fill_s loads the first byte into the output stage on PLAY entry.
    fill_s    = (state_r == ST_PLAY) & ~valid_r;
    xfer_s    = (state_r == ST_PLAY) & valid_r & bus.ready;
    end_s     = xfer_s & last_idx_s;
    advance_s = fill_s | (xfer_s & ~last_idx_s);
    // rd_data_r always holds the byte one ahead of value_r.
    rd_en_s   = (state_r == ST_PRIME) | advance_s;
    rd_addr_s = (state_r == ST_PRIME) ? RD_ZERO : (rd_ptr_r + RD_ONE);
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_LOAD:  state_s = finish_s ? ST_PRIME : ST_LOAD;
      ST_PRIME: state_s = len_zero_s ? ST_DONE : ST_PLAY;
      ST_PLAY:  state_s = end_s ? ST_DONE : ST_PLAY;
      ST_DONE:  state_s = ST_DONE;
      default:  state_s = ST_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_s;
    end
  end

  // Byte RAM: write during load, registered read-ahead during replay.
  always_ff @(posedge clk) begin
    if (store_s) begin
      mem_r[wr_ptr_r[ADDR_W-1:0]] <= bus.in_data;
    end
    if (rd_en_s) begin
      rd_data_r <= mem_r[rd_addr_s];
    end
  end

  // Load statistics, replay output stage and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r     <= PTR_ZERO;
      rd_ptr_r     <= RD_ZERO;
      last_lf_r    <= 1'b0;
      line_width_r <= 16'd0;
      row_count_r  <= 16'd0;
      done_r       <= 1'b0;
      overflow_r   <= 1'b0;
      valid_r      <= 1'b0;
      value_r      <= 8'd0;
      counter_r    <= 32'd0;
    end else begin
      if (store_s) begin
        wr_ptr_r  <= wr_ptr_r + PTR_ONE;
        last_lf_r <= is_lf_s;
        // A zero width marks "no newline seen yet"; real widths are >= 1.
        if (is_lf_s && (line_width_r == 16'd0)) begin
          line_width_r <= 16'(wr_ptr_r) + 16'd1;
        end
      end
      // A stored LF and an unterminated-row close never coincide.
      if ((store_s & is_lf_s) | close_row_s) begin
        row_count_r <= row_count_r + 16'd1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (state_r == ST_PRIME) begin
        rd_ptr_r <= RD_ZERO;
        if (len_zero_s) begin
          done_r <= 1'b1;
        end
      end
      if (advance_s) begin
        value_r   <= rd_data_r;
        valid_r   <= 1'b1;
        rd_ptr_r  <= rd_ptr_r + RD_ONE;
        counter_r <= fill_s ? 32'd0 : (counter_r + 32'd1);
      end
      if (end_s) begin
        valid_r   <= 1'b0;
        done_r    <= 1'b1;
        counter_r <= 32'(wr_ptr_r);
      end
    end
  end
endmodule

// File: tb/tb_schematic_feeder.sv
// tb_schematic_feeder
//   Directed bench for schematic_feeder: a full-size instance for the stream
//   scenarios and an ADDR_W=3 instance for the capacity overflow case.
module tb_schematic_feeder;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] line_width, row_count, lw_s, rc_s;
  logic        done, overflow, done_s, ovf_s;

  schematic_feeder_if bus();
  schematic_feeder_if bus_s();

  schematic_feeder #(.ADDR_W(15)) u_dut (
    .clk(clk), .reset(reset), .bus(bus),
    .line_width(line_width), .row_count(row_count),
    .done(done), .overflow(overflow)
  );

  schematic_feeder #(.ADDR_W(3)) u_small (
    .clk(clk), .reset(reset), .bus(bus_s),
    .line_width(lw_s), .row_count(rc_s),
    .done(done_s), .overflow(ovf_s)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  stim_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  cap_val[$];
  logic [31:0] cap_cnt[$];
  int          stab_err;
  int          first_cyc;
  bit          drain_to;

  task automatic set_stim(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.ready = 1'b0;
    bus_s.in_valid = 1'b0; bus_s.in_last = 1'b0; bus_s.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Pushes stim_q into the full-size instance, one byte per cycle.
  task automatic load();
    for (int i = 0; i < stim_q.size(); i++) begin
      bus.in_data  = stim_q[i];
      bus.in_valid = 1'b1;
      bus.in_last  = (i == stim_q.size() - 1);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Consumes the replay stream of the selected instance into cap_val/cap_cnt.
  task automatic drain(input bit sel, input bit toggle);
    logic        hold, r, v;
    logic [7:0]  hv, val;
    logic [31:0] hc, cnt;
    cap_val.delete(); cap_cnt.delete();
    stab_err = 0; first_cyc = -1; hold = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      r = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.ready = r; bus_s.ready = r;
      @(negedge clk);
      v   = sel ? bus_s.valid : bus.valid;
      val = sel ? bus_s.value : bus.value;
      cnt = sel ? bus_s.counter : bus.counter;
      if (hold && (val !== hv || cnt !== hc)) stab_err++;
      hold = 1'b0;
      if (v === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (v === 1'b1 && r) begin
        cap_val.push_back(val); cap_cnt.push_back(cnt);
      end else if (v === 1'b1) begin
        hold = 1'b1; hv = val; hc = cnt;
      end
      @(posedge clk);
      #1;
      if ((sel ? done_s : done) === 1'b1) break;
    end
    drain_to = ((sel ? done_s : done) !== 1'b1);
    bus.ready = 1'b0; bus_s.ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    n_vec++;
    if ({bus.in_ready, bus.valid, bus.value, bus.counter, line_width, row_count, done, overflow}
        !== {1'b1, 1'b0, 8'h00, 32'd0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_big got rdy=%b v=%b val=%h cnt=%0d lw=%0d rc=%0d d=%b o=%b want 1 0 00 0 0 0 0 0",
               bus.in_ready, bus.valid, bus.value, bus.counter, line_width, row_count, done, overflow);
    end
    n_vec++;
    if ({bus_s.in_ready, bus_s.valid, bus_s.value, bus_s.counter, lw_s, rc_s, done_s, ovf_s}
        !== {1'b1, 1'b0, 8'h00, 32'd0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_small got rdy=%b v=%b cnt=%0d d=%b o=%b want 1 0 0 0 0",
               bus_s.in_ready, bus_s.valid, bus_s.counter, done_s, ovf_s);
    end
  endtask

  task automatic test_basic();
    do_reset();
    set_stim("12\n.*\n");
    exp_q = stim_q;
    load();
    @(negedge clk);
    n_vec++;
    if (bus.valid !== 1'b0) begin n_err++; $display("FAIL basic_prime_valid got %b want 0", bus.valid); end
    @(posedge clk);
    #1;
    n_vec++;
    if (line_width !== 16'd3 || row_count !== 16'd2) begin
      n_err++; $display("FAIL basic_stats_early got lw=%0d rc=%0d want lw=3 rc=2", line_width, row_count);
    end
    drain(1'b0, 1'b0);
    n_vec++;
    if (drain_to || first_cyc != 1) begin
      n_err++; $display("FAIL basic_latency got first_cyc=%0d timeout=%b want 1 0", first_cyc, drain_to);
    end
    n_vec++;
    if (cap_val.size() != 6) begin n_err++; $display("FAIL basic_len got %0d want 6", cap_val.size()); end
    for (int i = 0; i < cap_val.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_val[i] !== exp_q[i] || cap_cnt[i] !== 32'(i)) begin
        n_err++; $display("FAIL basic_byte[%0d] got %h@%0d want %h@%0d", i, cap_val[i], cap_cnt[i], exp_q[i], i);
      end
    end
    n_vec++;
    if (done !== 1'b1 || bus.counter !== 32'd6 || bus.valid !== 1'b0 || line_width !== 16'd3 || row_count !== 16'd2) begin
      n_err++; $display("FAIL basic_end got d=%b cnt=%0d v=%b lw=%0d rc=%0d want 1 6 0 3 2",
                        done, bus.counter, bus.valid, line_width, row_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_stim("12\n.*\n");
    exp_q = stim_q;
    load();
    drain(1'b0, 1'b1);
    n_vec++;
    if (drain_to || stab_err != 0) begin
      n_err++; $display("FAIL bp_stable got stab_err=%0d timeout=%b want 0 0", stab_err, drain_to);
    end
    n_vec++;
    if (cap_val.size() != 6) begin n_err++; $display("FAIL bp_len got %0d want 6", cap_val.size()); end
    for (int i = 0; i < cap_val.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_val[i] !== exp_q[i] || cap_cnt[i] !== 32'(i)) begin
        n_err++; $display("FAIL bp_byte[%0d] got %h@%0d want %h@%0d", i, cap_val[i], cap_cnt[i], exp_q[i], i);
      end
    end
    n_vec++;
    if (done !== 1'b1 || bus.counter !== 32'd6 || bus.valid !== 1'b0) begin
      n_err++; $display("FAIL bp_end got d=%b cnt=%0d v=%b want 1 6 0", done, bus.counter, bus.valid);
    end
  endtask

  task automatic test_unterminated();
    do_reset();
    set_stim("ab\ncd");
    exp_q = stim_q;
    load();
    drain(1'b0, 1'b0);
    n_vec++;
    if (line_width !== 16'd3 || row_count !== 16'd2) begin
      n_err++; $display("FAIL unterm_stats got lw=%0d rc=%0d want lw=3 rc=2", line_width, row_count);
    end
    n_vec++;
    if (cap_val.size() != 5) begin n_err++; $display("FAIL unterm_len got %0d want 5", cap_val.size()); end
    for (int i = 0; i < cap_val.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_val[i] !== exp_q[i] || cap_cnt[i] !== 32'(i)) begin
        n_err++; $display("FAIL unterm_byte[%0d] got %h@%0d want %h@%0d", i, cap_val[i], cap_cnt[i], exp_q[i], i);
      end
    end
    n_vec++;
    if (done !== 1'b1 || bus.counter !== 32'd5) begin
      n_err++; $display("FAIL unterm_end got d=%b cnt=%0d want 1 5", done, bus.counter);
    end
  endtask

  task automatic test_crlf();
    logic [15:0] exp_lw;
    do_reset();
    stim_q = '{8'h31, 8'h0D, 8'h0A, 8'h32, 8'h0D, 8'h0A};
`ifdef FEEDER_CR_STRIP_EN
    exp_q  = '{8'h31, 8'h0A, 8'h32, 8'h0A};
    exp_lw = 16'd2;
`else
    exp_q  = '{8'h31, 8'h0D, 8'h0A, 8'h32, 8'h0D, 8'h0A};
    exp_lw = 16'd3;
`endif
    load();
    drain(1'b0, 1'b0);
    n_vec++;
    if (line_width !== exp_lw || row_count !== 16'd2) begin
      n_err++; $display("FAIL crlf_stats got lw=%0d rc=%0d want lw=%0d rc=2", line_width, row_count, exp_lw);
    end
    n_vec++;
    if (cap_val.size() != exp_q.size()) begin
      n_err++; $display("FAIL crlf_len got %0d want %0d", cap_val.size(), exp_q.size());
    end
    for (int i = 0; i < cap_val.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_val[i] !== exp_q[i] || cap_cnt[i] !== 32'(i)) begin
        n_err++; $display("FAIL crlf_byte[%0d] got %h@%0d want %h@%0d", i, cap_val[i], cap_cnt[i], exp_q[i], i);
      end
    end
    n_vec++;
    if (done !== 1'b1 || bus.counter !== 32'(exp_q.size())) begin
      n_err++; $display("FAIL crlf_end got d=%b cnt=%0d want 1 %0d", done, bus.counter, exp_q.size());
    end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      b = 8'h30 + 8'(i);
      bus_s.in_data  = b;
      bus_s.in_valid = 1'b1;
      bus_s.in_last  = (i == 9);
      n_vec++;
      if (bus_s.in_ready !== 1'b1) begin
        n_err++; $display("FAIL ovf_in_ready[%0d] got %b want 1", i, bus_s.in_ready);
      end
      @(posedge clk);
      #1;
    end
    bus_s.in_valid = 1'b0;
    bus_s.in_last  = 1'b0;
    n_vec++;
    if (ovf_s !== 1'b1 || lw_s !== 16'd0 || rc_s !== 16'd1) begin
      n_err++; $display("FAIL ovf_flags got o=%b lw=%0d rc=%0d want o=1 lw=0 rc=1", ovf_s, lw_s, rc_s);
    end
    drain(1'b1, 1'b0);
    n_vec++;
    if (cap_val.size() != 8) begin n_err++; $display("FAIL ovf_len got %0d want 8", cap_val.size()); end
    for (int i = 0; i < cap_val.size() && i < 8; i++) begin
      b = 8'h30 + 8'(i);
      n_vec++;
      if (cap_val[i] !== b || cap_cnt[i] !== 32'(i)) begin
        n_err++; $display("FAIL ovf_byte[%0d] got %h@%0d want %h@%0d", i, cap_val[i], cap_cnt[i], b, i);
      end
    end
    n_vec++;
    if (done_s !== 1'b1 || bus_s.counter !== 32'd8 || bus_s.valid !== 1'b0) begin
      n_err++; $display("FAIL ovf_end got d=%b cnt=%0d v=%b want 1 8 0", done_s, bus_s.counter, bus_s.valid);
    end
  endtask

  task automatic test_reset_play();
    bit found;
    do_reset();
    set_stim("12\n.*\n");
    load();
    bus.ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1 && bus.counter === 32'd3) begin
        found = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL rp_reach_cnt3 got not reached want counter=3"); end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.in_ready, bus.valid, bus.value, bus.counter, line_width, row_count, done, overflow}
        !== {1'b1, 1'b0, 8'h00, 32'd0, 16'd0, 16'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL rp_async_reset got rdy=%b v=%b val=%h cnt=%0d lw=%0d rc=%0d d=%b want 1 0 00 0 0 0 0",
               bus.in_ready, bus.valid, bus.value, bus.counter, line_width, row_count, done);
    end
    bus.ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    set_stim("x\n");
    exp_q = stim_q;
    load();
    drain(1'b0, 1'b0);
    n_vec++;
    if (cap_val.size() != 2) begin n_err++; $display("FAIL rp_len got %0d want 2", cap_val.size()); end
    for (int i = 0; i < cap_val.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (cap_val[i] !== exp_q[i] || cap_cnt[i] !== 32'(i)) begin
        n_err++; $display("FAIL rp_byte[%0d] got %h@%0d want %h@%0d", i, cap_val[i], cap_cnt[i], exp_q[i], i);
      end
    end
    n_vec++;
    if (line_width !== 16'd2 || row_count !== 16'd1 || overflow !== 1'b0 || done !== 1'b1 || bus.counter !== 32'd2) begin
      n_err++; $display("FAIL rp_end got lw=%0d rc=%0d o=%b d=%b cnt=%0d want 2 1 0 1 2",
                        line_width, row_count, overflow, done, bus.counter);
    end
  endtask

  initial begin
    bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.ready = 1'b0;
    bus_s.in_data = 8'h00; bus_s.in_valid = 1'b0; bus_s.in_last = 1'b0; bus_s.ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_unterminated();
    test_crlf();
    test_overflow();
    test_reset_play();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
